// File: rtl/mem_sys_banked.sv
// -----------------------------------------------------------------------------
// mem_sys_banked
//
// Banked scratchpad memory for the accelerator datapath. NUM_BANKS independent
// word-wide banks sit behind a single valid/ready request port. The port takes
// single-beat writes and auto-incrementing burst reads. Read beats come out of
// a registered output stage with no backpressure. Bank 0 holds activations,
// bank 1 holds weights, and any further banks hold partial sums.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   vdd        in   block enable (0 = gated: no accepts, bursts aborted)
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle
//   req_write  in   1 = write, 0 = read
//   req_bank   in   target bank
//   req_addr   in   start word address
//   req_wdata  in   write data
//   req_len    in   read beats minus one (ignored for writes)
//   rd_valid   out  read beat present
//   rd_data    out  read beat data (holds when rd_valid = 0)
//   rd_bank    out  bank the beat came from (holds when rd_valid = 0)
//   rd_last    out  final beat of a burst (holds when rd_valid = 0)
//   err        out  one-cycle pulse: accepted request hit bank >= NUM_BANKS
// -----------------------------------------------------------------------------
module mem_sys_banked #(
  parameter  int DATA_W    = 8,
  parameter  int ADDR_W    = 10,
  parameter  int NUM_BANKS = 2,
  parameter  int LEN_W     = 4,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vdd,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [BANK_W-1:0] rd_bank,
  output logic              rd_last,
  output logic              err
);

  // The bank count is widened by one bit. This keeps the range check exact
  // when NUM_BANKS is a power of two and therefore does not fit in BANK_W bits.
  localparam logic [BANK_W:0] NUM_BANKS_EXT = (BANK_W+1)'(NUM_BANKS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Bank storage. Reset does not clear it, and it is retained while gated.
  logic [DATA_W-1:0] mem [0:NUM_BANKS-1][0:(2**ADDR_W)-1];

  state_e            state_q,      state_d;
  logic [BANK_W-1:0] burst_bank_q, burst_bank_d;
  logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
  logic [LEN_W-1:0]  burst_rem_q,  burst_rem_d;
  logic              rd_valid_q,   rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,    rd_data_d;
  logic [BANK_W-1:0] rd_bank_q,    rd_bank_d;
  logic              rd_last_q,    rd_last_d;
  logic              err_q,        err_d;

  logic req_ready_s;
  logic accept_s;
  logic bank_ok_s;
  logic mem_we_s;

  // Request handshake. Ready is held low during reset so that nothing is
  // accepted on the reset edge.
  always_comb begin
    req_ready_s = vdd && !rst && (state_q == ST_IDLE);
    accept_s    = req_valid && req_ready_s;
    bank_ok_s   = ({1'b0, req_bank} < NUM_BANKS_EXT);
  end

  // Next-state logic for the FSM, the burst counters and the read output stage.
  always_comb begin
    state_d      = state_q;
    burst_bank_d = burst_bank_q;
    burst_addr_d = burst_addr_q;
    burst_rem_d  = burst_rem_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    rd_bank_d    = rd_bank_q;
    rd_last_d    = rd_last_q;
    err_d        = 1'b0;
    mem_we_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (!bank_ok_s) begin
            // A bad bank is consumed silently apart from the err pulse.
            err_d = 1'b1;
          end else if (req_write) begin
            mem_we_s = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[req_bank][req_addr];
            rd_bank_d  = req_bank;
            rd_last_d  = (req_len == LEN_W'(0));
            if (req_len != LEN_W'(0)) begin
              state_d      = ST_BURST;
              burst_bank_d = req_bank;
              burst_addr_d = req_addr + ADDR_W'(1);
              burst_rem_d  = req_len;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BURST: begin
        if (!vdd) begin
          // Gating aborts the burst. No beat is issued on this edge.
          state_d     = ST_IDLE;
          burst_rem_d = LEN_W'(0);
        end else begin
          // burst_rem_q counts the beats still to issue, including this one.
          // The address wraps naturally at 2**ADDR_W.
          rd_valid_d   = 1'b1;
          rd_data_d    = mem[burst_bank_q][burst_addr_q];
          rd_bank_d    = burst_bank_q;
          rd_last_d    = (burst_rem_q == LEN_W'(1));
          burst_addr_d = burst_addr_q + ADDR_W'(1);
          burst_rem_d  = burst_rem_q - LEN_W'(1);
          if (burst_rem_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BURST;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        burst_rem_d = LEN_W'(0);
      end
    endcase
  end

  // Registers for the FSM, the burst counters and the read output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      burst_bank_q <= '0;
      burst_addr_q <= '0;
      burst_rem_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_bank_q    <= '0;
      rd_last_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_bank_q <= burst_bank_d;
      burst_addr_q <= burst_addr_d;
      burst_rem_q  <= burst_rem_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_bank_q    <= rd_bank_d;
      rd_last_q    <= rd_last_d;
      err_q        <= err_d;
    end
  end

  // Memory write port. The word updates on the accept edge, so a read
  // accepted on the very next edge sees the new value.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[req_bank][req_addr] <= req_wdata;
    end
  end

  assign req_ready = req_ready_s;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_bank   = rd_bank_q;
  assign rd_last   = rd_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_sys_banked.sv
// -----------------------------------------------------------------------------
// tb_mem_sys_banked
//
// Directed self-checking bench for mem_sys_banked with NUM_BANKS = 3, so that
// bank index 3 is out of range. Inputs are driven and outputs are sampled
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_sys_banked;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 10;
  localparam int NUM_BANKS = 3;
  localparam int LEN_W     = 4;
  localparam int BANK_W    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              vdd;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [BANK_W-1:0] req_bank;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [BANK_W-1:0] rd_bank;
  logic              rd_last;
  logic              err;

  int checks = 0;
  int errors = 0;

  mem_sys_banked #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_BANKS(NUM_BANKS),
    .LEN_W    (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vdd      (vdd),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_bank (req_bank),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_len  (req_len),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_bank  (rd_bank),
    .rd_last  (rd_last),
    .err      (err)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Single-beat write. Ready is checked first, then the request is accepted
  // on one edge, and no read beat may follow it.
  task automatic do_write(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic exp_err);
    chk("wr_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_bank = b; req_addr = a;
    req_wdata = d;    req_len   = 4'd0;
    tick();
    req_valid = 1'b0;
    chk("wr_no_beat", 32'(rd_valid), 32'd0);
    chk("wr_err", 32'(err), 32'(exp_err));
  endtask

  // Single-beat read. The beat must appear in the cycle after the accept.
  task automatic do_read1(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input string tag);
    req_valid = 1'b1; req_write = 1'b0; req_bank = b; req_addr = a; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"},  32'(rd_data),  32'(d));
    chk({tag, "_bank"},  32'(rd_bank),  32'(b));
    chk({tag, "_last"},  32'(rd_last),  32'd1);
  endtask

  initial begin
    rst = 1'b1; vdd = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_bank = '0; req_addr = '0; req_wdata = '0; req_len = '0;

    // Reset state, sampled while rst is still high.
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rd_valid),  32'd0);
    chk("rst_data",  32'(rd_data),   32'd0);
    chk("rst_bank",  32'(rd_bank),   32'd0);
    chk("rst_last",  32'(rd_last),   32'd0);
    chk("rst_err",   32'(err),       32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Write, then a single read on the very next edge.
    do_write(2'd0, 10'd5, 8'hA5, 1'b0);
    do_read1(2'd0, 10'd5, 8'hA5, "wr_rd");
    tick();
    chk("wr_rd_idle", 32'(rd_valid), 32'd0);

    // Bank isolation at the same address.
    do_write(2'd0, 10'd3, 8'h11, 1'b0);
    do_write(2'd1, 10'd3, 8'h22, 1'b0);
    do_write(2'd2, 10'd0, 8'h77, 1'b0);
    do_read1(2'd0, 10'd3, 8'h11, "iso_b0");
    do_read1(2'd1, 10'd3, 8'h22, "iso_b1");

    // Wrapping burst, with a back-to-back single read queued behind it.
    do_write(2'd1, 10'h3FE, 8'd1, 1'b0);
    do_write(2'd1, 10'h3FF, 8'd2, 1'b0);
    do_write(2'd1, 10'h000, 8'd3, 1'b0);
    do_write(2'd1, 10'h001, 8'd4, 1'b0);
    req_valid = 1'b1; req_write = 1'b0; req_bank = 2'd1; req_addr = 10'h3FE; req_len = 4'd3;
    tick();
    req_bank = 2'd0; req_addr = 10'd5; req_len = 4'd0;
    for (int k = 0; k < 4; k++) begin
      chk("burst_valid", 32'(rd_valid),  32'd1);
      chk("burst_data",  32'(rd_data),   32'(k + 1));
      chk("burst_bank",  32'(rd_bank),   32'd1);
      chk("burst_last",  32'(rd_last),   (k == 3) ? 32'd1 : 32'd0);
      chk("burst_ready", 32'(req_ready), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    req_valid = 1'b0;
    chk("b2b_valid", 32'(rd_valid), 32'd1);
    chk("b2b_data",  32'(rd_data),  32'hA5);
    chk("b2b_bank",  32'(rd_bank),  32'd0);
    chk("b2b_last",  32'(rd_last),  32'd1);
    tick();
    chk("b2b_idle", 32'(rd_valid), 32'd0);

    // Out-of-range bank: the write is dropped, and the burst read makes no beats.
    do_write(2'd3, 10'd0, 8'h55, 1'b1);
    tick();
    chk("oor_err_pulse", 32'(err), 32'd0);
    req_valid = 1'b1; req_write = 1'b0; req_bank = 2'd3; req_addr = 10'd0; req_len = 4'd2;
    tick();
    req_valid = 1'b0;
    chk("oor_rd_err",   32'(err),       32'd1);
    chk("oor_rd_valid", 32'(rd_valid),  32'd0);
    chk("oor_rd_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("oor_no_beat", 32'(rd_valid), 32'd0);
      chk("oor_err_low", 32'(err),      32'd0);
    end
    do_read1(2'd0, 10'd3, 8'h11, "oor_b0");
    do_read1(2'd1, 10'd3, 8'h22, "oor_b1");
    do_read1(2'd2, 10'd0, 8'h77, "oor_b2");

    // Abort a len=7 burst by gating after beat 1.
    for (int k = 0; k < 8; k++) begin
      do_write(2'd0, 10'(16 + k), 8'(8'h80 + k), 1'b0);
    end
    req_valid = 1'b1; req_write = 1'b0; req_bank = 2'd0; req_addr = 10'd16; req_len = 4'd7;
    tick();
    req_valid = 1'b0;
    chk("abort_b0", 32'(rd_data), 32'h80);
    tick();
    chk("abort_b1_valid", 32'(rd_valid), 32'd1);
    chk("abort_b1", 32'(rd_data), 32'h81);
    vdd = 1'b0;
    #1;
    chk("gated_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_beat", 32'(rd_valid), 32'd0);
    end
    vdd = 1'b1;
    #1;
    chk("ungated_ready", 32'(req_ready), 32'd1);
    do_read1(2'd0, 10'd18,   8'h82, "retain_b0");
    do_read1(2'd1, 10'h3FF, 8'd2,  "retain_b1");

    // Reset in the middle of a burst.
    req_valid = 1'b1; req_write = 1'b0; req_bank = 2'd0; req_addr = 10'd16; req_len = 4'd7;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(rd_valid),  32'd0);
    chk("mid_rst_data",  32'(rd_data),   32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("after_rst_valid", 32'(rd_valid),  32'd0);
    chk("after_rst_ready", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sys_banked.md
# mem_sys_banked

Parametrised banked scratchpad memory for the accelerator datapath, succeeding the fixed two-bank, bit-serial memory system. It provides NUM_BANKS independent word-wide banks (bank 0 = activations "x", bank 1 = weights "w", further banks for partial sums). Access is through one valid/ready request port, with single-beat writes and auto-incrementing burst reads. It sits between the host/loader and the MAC array, and feeds read beats directly to the array.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 10, per-bank address width; bank depth = 2**ADDR_W words
- NUM_BANKS, 2, number of banks, legal range 1..16
- LEN_W, 4, burst length field width; bursts of 1..2**LEN_W beats
- BANK_W (localparam), max(1, clog2(NUM_BANKS))

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- vdd  in  1  block enable; 0 = gated
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_bank  in  BANK_W  target bank
- req_addr  in  ADDR_W  start word address
- req_wdata  in  DATA_W  write data
- req_len  in  LEN_W  read beats minus 1; ignored for writes
- rd_valid  out  1  read beat present; no backpressure
- rd_data  out  DATA_W  read beat data
- rd_bank  out  BANK_W  bank the beat came from
- rd_last  out  1  final beat of a burst
- err  out  1  one-cycle pulse: accepted request targeted bank >= NUM_BANKS

## Operation
- Storage: NUM_BANKS arrays of 2**ADDR_W x DATA_W. Contents are not cleared by rst or vdd=0. Reads of never-written words return unspecified data.
- A request is accepted on a rising edge where req_valid && req_ready.
- FSM states:
  - IDLE: req_ready = vdd.
  - BURST: req_ready = 0. Holds bank, next address, beats remaining.
- Write accept: the addressed word is updated at the accept edge. No rd_valid is generated. FSM stays IDLE.
- Read accept with req_len = 0: single beat. FSM stays IDLE.
- Read accept with req_len = L > 0: FSM goes to BURST. One further read is issued per cycle at addresses req_addr+1 .. req_addr+L. Addresses wrap modulo 2**ADDR_W, so 0x3FF is followed by 0x000 at ADDR_W=10. The FSM returns to IDLE after the read of beat L is issued.
- rd_last = 1 on the final beat of every read, including single-beat reads.
- Out-of-range bank (req_bank >= NUM_BANKS): the request is accepted and err pulses in the next cycle. A write is dropped. A read produces no beats and no burst. The FSM stays IDLE.
- vdd = 0: req_ready = 0. An in-progress burst is aborted and the FSM goes to IDLE. From the next cycle, rd_valid = 0 and no further beats are produced. Memory contents are retained.
- A read issued the cycle after a write to the same bank and address returns the new data.

## Timing
- Reset values: req_ready = 0 during the rst cycle, 1 from the first cycle after rst deasserts if vdd = 1. rd_valid = 0, rd_data = 0, rd_bank = 0, rd_last = 0, err = 0. FSM is IDLE, burst counters are 0.
- Read latency: read accepted at edge T → beat 0 valid in cycle T+1, beat k valid in cycle T+1+k. Output is registered.
- req_ready is low in cycles T+1 .. T+L and high again in cycle T+L+1. Back-to-back requests therefore give gapless rd_valid.
- rd_data, rd_bank and rd_last hold their last values when rd_valid = 0. Benches compare them only while rd_valid = 1.
- rst asserted mid-burst: at that edge all outputs return to reset values, remaining beats are discarded, and the FSM goes to IDLE.
- err is asserted only in cycle T+1 for a bad request accepted at T.

## Test plan
- Write then single read: write bank0 addr 5 = 0xA5 at T, read bank0 addr 5 at T+1 → rd_valid in cycle T+2, rd_data = 0xA5, rd_bank = 0, rd_last = 1.
- Bank isolation: write bank0 addr 3 = 0x11 and bank1 addr 3 = 0x22, then read both → data is 0x11 and 0x22 respectively, with the matching rd_bank.
- Wrap burst: preload bank1 addrs 0x3FE, 0x3FF, 0x000, 0x001 with 1, 2, 3, 4, then read at 0x3FE with len = 3 → four consecutive beats 1, 2, 3, 4. rd_last only on beat 4. req_ready low for exactly 3 cycles.
- Back-to-back: single read accepted the cycle req_ready rises after a burst → rd_valid continuous with no bubble.
- Out-of-range bank (NUM_BANKS = 3, BANK_W = 2): write bank3 addr 0 = 0x55 → err pulses for one cycle. A subsequent read of bank3 produces err and no rd_valid. Contents of banks 0..2 are unchanged.
- Abort: vdd = 0 after beat 1 of a len = 7 burst → no rd_valid from the next cycle. With vdd = 1 again, req_ready = 1, and data previously written is still readable.
